// File: rtl/btn_debounce.sv
// Raw pushbutton conditioner: 2-FF synchronizer, per-button debounce FSM, level, press/release pulses, 8-bit press count.
// Latency 2+DEBOUNCE_CYCLES clk edges from raw sample to level/pulse; no backpressure, every output is a free-running register.
// Optional auto-repeat pulses are built only when BTN_REPEAT_EN is defined; otherwise btn_repeat is tied to 0.
module btn_debounce #(
    parameter int N_BTN           = 4,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BTN-1:0]     btn_raw,
    output logic [N_BTN-1:0]     btn_state,
    output logic [N_BTN-1:0]     btn_press,
    output logic [N_BTN-1:0]     btn_release,
    output logic [N_BTN-1:0]     btn_repeat,
    output logic [8*N_BTN-1:0]   press_cnt
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        P_HIGH = 2'd1,
        S_HIGH = 2'd2,
        P_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (N_BTN < 1 || N_BTN > 16) begin : g_bad_n_btn
        $error("btn_debounce: N_BTN must be 1..16");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_CYCLES must be at least 1");
    end

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic [7:0]       pcnt_q, pcnt_d;
        logic             s;

        assign s = sync2_q[g];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            pcnt_d  = pcnt_q;
            case (state_q)
                S_LOW: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = S_HIGH;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            pcnt_d  = pcnt_q + 8'd1;
                        end else begin
                            state_d = P_HIGH;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                P_HIGH: begin
                    if (!s) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        pcnt_d  = pcnt_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = S_LOW;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                        end else begin
                            state_d = P_LOW;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                P_LOW: begin
                    if (s) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= S_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                pcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                pcnt_q  <= pcnt_d;
            end
        end

        assign btn_state[g]          = level_q;
        assign btn_press[g]          = press_q;
        assign btn_release[g]        = rel_q;
        assign press_cnt[8*g +: 8]   = pcnt_q;

`ifdef BTN_REPEAT_EN
        localparam int             RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
        localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

        logic [RPT_W-1:0] rpt_q, rpt_d;
        logic             rep_q, rep_d;

        // Counter only advances while settled high; any other state holds it at zero.
        always_comb begin
            rpt_d = '0;
            rep_d = 1'b0;
            if (state_q == S_HIGH) begin
                if (rpt_q == RPT_LAST) begin
                    rep_d = 1'b1;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rpt_q <= '0;
                rep_q <= 1'b0;
            end else begin
                rpt_q <= rpt_d;
                rep_q <= rep_d;
            end
        end

        assign btn_repeat[g] = rep_q;
`else
        assign btn_repeat[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: run-length/timestamp reference model compared every cycle, plus directed literal checks.
module tb_btn_debounce;

    localparam int N = 2;
    localparam int D = 4;
    localparam int R = 10;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_state, btn_press, btn_release, btn_repeat;
    logic [8*N-1:0] press_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN(N), .CNT_W(16), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .press_cnt(press_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a level flips once D consecutive synchronized samples disagree with it.
    logic [N-1:0] m_sy1 = '0, m_sy2 = '0, m_state = '0;
    logic [N-1:0] m_press = '0, m_rel = '0, m_rep = '0;
    int m_run[N], m_cnt[N], m_since[N];
    logic [15:0] m_pc;

    always @(posedge clk) begin : model
        logic s, was_hi;
        cyc++;
        if (!rst_n) begin
            m_sy1 = '0; m_sy2 = '0; m_state = '0;
            m_press = '0; m_rel = '0; m_rep = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_cnt[i] = 0; m_since[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                s      = m_sy2[i];
                was_hi = m_state[i] && (m_run[i] == 0);
                m_press[i] = 1'b0; m_rel[i] = 1'b0; m_rep[i] = 1'b0;
                if (s != m_state[i]) m_run[i]++;
                else                 m_run[i] = 0;
                if (m_run[i] == D) begin
                    m_state[i] = s;
                    m_run[i]   = 0;
                    if (s) begin
                        m_press[i] = 1'b1;
                        m_cnt[i]   = (m_cnt[i] + 1) % 256;
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                end
                if (REP_EN && was_hi && ((cyc - m_since[i]) % R == 0))
                    m_rep[i] = 1'b1;
                if (!was_hi && m_state[i] && m_run[i] == 0)
                    m_since[i] = cyc;
            end
            m_sy2 = m_sy1;
            m_sy1 = btn_raw;
        end
        m_pc = {m_cnt[1][7:0], m_cnt[0][7:0]};
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("model_state",   32'(btn_state),   32'(m_state));
            chk("model_press",   32'(btn_press),   32'(m_press));
            chk("model_release", 32'(btn_release), 32'(m_rel));
            chk("model_repeat",  32'(btn_repeat),  32'(m_rep));
            chk("model_cnt",     32'(press_cnt),   32'(m_pc));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic pat [8];
        int   np, press_at;
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset held 3 edges with both buttons pressed.
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        for (int k = 0; k < 3; k++) begin
            edges(1);
            chk("reset_all_zero", 32'({btn_state, btn_press, btn_release, btn_repeat, press_cnt}), 32'd0);
        end
        rst_n = 1'b1;
        edges(5);
        chk("post_reset_press_early", 32'(btn_press), 32'h0);
        edges(1);
        chk("post_reset_press_6", 32'(btn_press), 32'h3);
        chk("post_reset_state",   32'(btn_state), 32'h3);
        chk("post_reset_cnt",     32'(press_cnt), 32'h0101);
        edges(1);
        chk("post_reset_pulse_1cyc", 32'(btn_press), 32'h0);

        // Clean release then press on button 0.
        btn_raw = 2'b10;
        edges(5);
        chk("release_early", 32'(btn_release), 32'h0);
        edges(1);
        chk("release_6",     32'(btn_release), 32'h1);
        chk("release_state", 32'(btn_state),   32'h2);
        chk("release_cnt",   32'(press_cnt),   32'h0101);
        edges(1);
        chk("release_1cyc",  32'(btn_release), 32'h0);
        btn_raw = 2'b11;
        edges(5);
        chk("press0_early", 32'(btn_press), 32'h0);
        edges(1);
        chk("press0_6",     32'(btn_press), 32'h1);
        chk("press0_state", 32'(btn_state), 32'h3);
        chk("press0_cnt",   32'(press_cnt), 32'h0102);

        // Bounce on button 1: runs of three are rejected, then a steady hold.
        btn_raw = 2'b01;
        edges(10);
        np = 0; press_at = 0;
        for (int k = 1; k <= 20; k++) begin
            btn_raw[1] = (k <= 8) ? pat[k-1] : 1'b1;
            edges(1);
            if (btn_press[1]) begin
                np++;
                if (press_at == 0) press_at = k;
            end
            if (k == 13) chk("bounce_state_low", 32'(btn_state[1]), 32'h0);
        end
        chk("bounce_single_press", 32'(np), 32'd1);
        chk("bounce_press_edge",   32'(press_at), 32'd14);
        chk("bounce_cnt1",         32'(press_cnt[15:8]), 32'h02);

        // Counter wrap on button 0 after clearing counts with a reset.
        btn_raw = 2'b00;
        edges(8);
        rst_n = 1'b0;
        edges(2);
        rst_n = 1'b1;
        edges(3);
        chk("wrap_start", 32'(press_cnt), 32'h0);
        for (int p = 1; p <= 256; p++) begin
            btn_raw[0] = 1'b1;
            edges(7);
            btn_raw[0] = 1'b0;
            edges(7);
            if (p == 255) chk("wrap_ff", 32'(press_cnt[7:0]), 32'hFF);
            if (p == 256) begin
                chk("wrap_00", 32'(press_cnt[7:0]),  32'h00);
                chk("wrap_b1", 32'(press_cnt[15:8]), 32'h00);
            end
        end

        // Reset while button 0 is mid-debounce (P_HIGH, cnt=2).
        btn_raw = 2'b01;
        edges(4);
        rst_n = 1'b0;
        edges(1);
        chk("midrst_no_press", 32'({btn_press, btn_state}), 32'h0);
        rst_n = 1'b1;
        edges(5);
        chk("midrst_early", 32'(btn_press), 32'h0);
        edges(1);
        chk("midrst_press_6", 32'(btn_press), 32'h1);
        chk("midrst_cnt",     32'(press_cnt), 32'h0001);

        // Hold for auto-repeat: pulses at +10/+20/+30 only when built in.
        for (int k = 1; k <= 35; k++) begin
            edges(1);
            chk("repeat0", 32'(btn_repeat[0]), 32'(REP_EN && (k % 10 == 0)));
        end
        chk("repeat_cnt_unchanged", 32'(press_cnt), 32'h0001);

        btn_raw = 2'b00;
        edges(8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
